// File: rtl/datapath.sv
// Single-cycle RV64 integer datapath: PC, instruction ROM, register file, immediate
// generator, ALU and data memory. Decode and branch decisions are supplied externally.
module datapath (
    input  logic        Clk,
    output logic [31:0] Instruction,
    output logic        zero,
    output logic [63:0] PCNow,
    output logic [63:0] PCNext4,
    input  logic        Reset,
    input  logic [63:0] NewPC,
    input  logic        Jump,
    input  logic        PCWrite,
    input  logic        RegWrite,
    input  logic        ALUSrc,
    input  logic [3:0]  Operation,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemToReg,
    output logic [63:0] writedataa,
    output logic [63:0] readdata1,
    output logic [63:0] readdata2
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Same contents are restored by Reset and present at power-up.
    localparam logic [63:0] RF_INIT   [32] = '{6: 64'd2, 7: 64'd3, default: 64'd0};
    localparam logic [63:0] DMEM_INIT [64] = '{23: 64'd3, default: 64'd0};

    logic [63:0] pc = 64'd0;
    logic [63:0] rf   [32] = RF_INIT;
    logic [63:0] dmem [64] = DMEM_INIT;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [63:0] imm;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic [63:0] mem_rdata;

    assign PCNow   = pc;
    assign PCNext4 = pc + 64'd4;

    // Word-indexed ROM; PC bits above [7:2] are ignored, so it wraps every 256 bytes.
    always_comb begin
        Instruction = 32'h0000_0000;
        case (pc[7:2])
            6'd0:    Instruction = 32'h00E0_8793; // addi x15,x1,14
            6'd1:    Instruction = 32'h0073_02B3; // add  x5,x6,x7
            6'd2:    Instruction = 32'h0057_82B3; // add  x5,x15,x5
            6'd3:    Instruction = 32'h4067_87B3; // sub  x15,x15,x6
            6'd4:    Instruction = 32'h0042_B783; // ld   x15,4(x5)
            6'd5:    Instruction = 32'h00F0_0033; // add  x0,x0,x15
            6'd6:    Instruction = 32'h0057_B023; // sd   x5,0(x15)
            6'd7:    Instruction = 32'h0007_B283; // ld   x5,0(x15)
            6'd8:    Instruction = 32'h0057_82B3; // add  x5,x15,x5
            6'd9:    Instruction = 32'h00F2_8263; // beq  x5,x15,4
            6'd10:   Instruction = 32'h0057_82B3; // add  x5,x15,x5
            default: Instruction = 32'h0000_0000;
        endcase
    end

    assign rs1    = Instruction[19:15];
    assign rs2    = Instruction[24:20];
    assign rd     = Instruction[11:7];
    assign opcode = Instruction[6:0];

    assign readdata1 = (rs1 == 5'd0) ? 64'd0 : rf[rs1];
    assign readdata2 = (rs2 == 5'd0) ? 64'd0 : rf[rs2];

    always_comb begin
        imm = 64'd0;
        case (opcode)
            OPC_LOAD, OPC_ALUI:
                imm = {{52{Instruction[31]}}, Instruction[31:20]};
            OPC_STORE:
                imm = {{52{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
            OPC_BRANCH:
                imm = {{51{Instruction[31]}}, Instruction[31], Instruction[7],
                       Instruction[30:25], Instruction[11:8], 1'b0};
            default:
                imm = 64'd0;
        endcase
    end

    assign alu_b = ALUSrc ? imm : readdata2;

    always_comb begin
        alu_result = 64'd0;
        case (Operation)
            ALU_AND: alu_result = readdata1 & alu_b;
            ALU_OR:  alu_result = readdata1 | alu_b;
            ALU_ADD: alu_result = readdata1 + alu_b;
            ALU_SUB: alu_result = readdata1 - alu_b;
            ALU_SLT: alu_result = ($signed(readdata1) < $signed(alu_b)) ? 64'd1 : 64'd0;
            ALU_NOR: alu_result = ~(readdata1 | alu_b);
            default: alu_result = 64'd0;
        endcase
    end

    assign zero = (alu_result == 64'd0);

    // Data memory is indexed by entry, not by byte address.
    assign mem_rdata  = MemRead ? dmem[alu_result[5:0]] : 64'd0;
    assign writedataa = MemToReg ? alu_result : mem_rdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc <= 64'd0;
        end else if (PCWrite) begin
            pc <= Jump ? NewPC : PCNext4;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rf <= RF_INIT;
        end else if (RegWrite && (rd != 5'd0)) begin
            rf[rd] <= writedataa;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dmem <= DMEM_INIT;
        end else if (MemWrite) begin
            dmem[alu_result[5:0]] <= readdata2;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed program walk plus randomized control against a
// behavioural model of the machine state (PC, registers, memory).
module tb_datapath;

    logic        clk = 1'b0;
    logic [31:0] Instruction;
    logic        zero;
    logic [63:0] PCNow;
    logic [63:0] PCNext4;
    logic        Reset = 1'b0;
    logic [63:0] NewPC = 64'd0;
    logic        Jump = 1'b0;
    logic        PCWrite = 1'b0;
    logic        RegWrite = 1'b0;
    logic        ALUSrc = 1'b0;
    logic [3:0]  Operation = 4'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemToReg = 1'b0;
    logic [63:0] writedataa;
    logic [63:0] readdata1;
    logic [63:0] readdata2;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    always #5 clk = ~clk;

    datapath dut (
        .Clk(clk), .Instruction(Instruction), .zero(zero), .PCNow(PCNow),
        .PCNext4(PCNext4), .Reset(Reset), .NewPC(NewPC), .Jump(Jump),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .Operation(Operation), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemToReg(MemToReg), .writedataa(writedataa), .readdata1(readdata1),
        .readdata2(readdata2)
    );

    int checks = 0;
    int errors = 0;

    // Architectural state of the reference model
    logic [31:0] rom_m [64];
    logic [63:0] rf_m  [32];
    logic [63:0] mem_m [64];
    logic [63:0] pc_m;

    // Values the model predicts for the current cycle
    logic [31:0] e_inst;
    logic [63:0] e_r1, e_r2, e_alu, e_wb;
    logic [4:0]  e_rd;

    function automatic void model_reset();
        foreach (rf_m[i]) rf_m[i] = 64'd0;
        foreach (mem_m[i]) mem_m[i] = 64'd0;
        rf_m[6]   = 64'd2;
        rf_m[7]   = 64'd3;
        mem_m[23] = 64'd3;
        pc_m      = 64'd0;
    endfunction

    function automatic logic [63:0] imm_of(input logic [31:0] i);
        logic [63:0] v;
        case (i[6:0])
            7'b0000011, 7'b0010011: v = {{52{i[31]}}, i[31:20]};
            7'b0100011:             v = {{52{i[31]}}, i[31:25], i[11:7]};
            7'b1100011:             v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default:                v = 64'd0;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] alu_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] v;
        case (op)
            4'b0000: v = a & b;
            4'b0001: v = a | b;
            4'b0010: v = a + b;
            4'b0110: v = a - b;
            4'b0111: v = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b1100: v = ~(a | b);
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's controls, let the datapath settle, compare against the model.
    task automatic drive(input logic rst, input logic pcw, input logic jmp, input logic [63:0] npc,
                         input logic rw, input logic asrc, input logic [3:0] op,
                         input logic mw, input logic mr, input logic m2r);
        logic [63:0] b, md;
        Reset = rst; PCWrite = pcw; Jump = jmp; NewPC = npc; RegWrite = rw;
        ALUSrc = asrc; Operation = op; MemWrite = mw; MemRead = mr; MemToReg = m2r;
        #2;
        e_inst = rom_m[pc_m[7:2]];
        e_rd   = e_inst[11:7];
        e_r1   = rf_m[e_inst[19:15]];
        e_r2   = rf_m[e_inst[24:20]];
        b      = asrc ? imm_of(e_inst) : e_r2;
        e_alu  = alu_of(op, e_r1, b);
        md     = mr ? mem_m[e_alu[5:0]] : 64'd0;
        e_wb   = m2r ? e_alu : md;
        check("pcnow", PCNow, pc_m);
        check("pcnext4", PCNext4, pc_m + 64'd4);
        check("instruction", 64'(Instruction), 64'(e_inst));
        check("readdata1", readdata1, e_r1);
        check("readdata2", readdata2, e_r2);
        check("writedataa", writedataa, e_wb);
        check("zero", 64'(zero), 64'(e_alu == 64'd0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (Reset) begin
            model_reset();
        end else begin
            if (RegWrite && e_rd != 5'd0) rf_m[e_rd] = e_wb;
            if (MemWrite) mem_m[e_alu[5:0]] = e_r2;
            if (PCWrite) pc_m = Jump ? NewPC : pc_m + 64'd4;
        end
        #1;
    endtask

    initial begin
        logic        r_rst, r_pcw, r_jmp;
        logic [63:0] r_npc;

        foreach (rom_m[i]) rom_m[i] = 32'h0;
        rom_m[0]  = 32'h00E08793; // addi x15,x1,14
        rom_m[1]  = 32'h007302B3; // add  x5,x6,x7
        rom_m[2]  = 32'h005782B3; // add  x5,x15,x5
        rom_m[3]  = 32'h406787B3; // sub  x15,x15,x6
        rom_m[4]  = 32'h0042B783; // ld   x15,4(x5)
        rom_m[5]  = 32'h00F00033; // add  x0,x0,x15
        rom_m[6]  = 32'h0057B023; // sd   x5,0(x15)
        rom_m[7]  = 32'h0007B283; // ld   x5,0(x15)
        rom_m[8]  = 32'h005782B3; // add  x5,x15,x5
        rom_m[9]  = 32'h00F28263; // beq  x5,x15,4
        rom_m[10] = 32'h005782B3; // add  x5,x15,x5
        model_reset();

        @(posedge clk);
        #1;
        // Power-up contents, no reset yet
        drive(N, N, N, 64'd0, N, N, OP_ADD, N, N, Y);
        check("powerup_inst", 64'(Instruction), 64'h00E08793);
        tick();

        // Reset with every write enable active
        drive(Y, Y, Y, 64'h80, Y, N, OP_ADD, Y, N, Y);
        tick();

        // args: rst pcw jmp npc | rw asrc op | mw mr m2r
        drive(N, Y, N, 64'd0, Y, Y, OP_ADD, N, N, Y);            // addi
        check("rst_pcnow", PCNow, 64'd0);
        check("rst_pcnext4", PCNext4, 64'd4);
        check("rst_inst", 64'(Instruction), 64'h00E08793);
        check("rst_rd1", readdata1, 64'd0);
        check("addi_wb", writedataa, 64'd14);
        tick();
        drive(N, Y, N, 64'd0, Y, N, OP_ADD, N, N, Y);            // add x5,x6,x7
        check("add1_wb", writedataa, 64'd5);
        tick();
        drive(N, Y, N, 64'd0, Y, N, OP_ADD, N, N, Y);            // add x5,x15,x5
        check("x15_after_addi", readdata1, 64'd14);
        check("add2_wb", writedataa, 64'd19);
        tick();
        drive(N, Y, N, 64'd0, Y, N, OP_SUB, N, N, Y);            // sub
        check("sub_wb", writedataa, 64'd12);
        tick();
        drive(N, Y, N, 64'd0, Y, Y, OP_ADD, N, Y, N);            // ld x15,4(x5)
        check("ld23_wb", writedataa, 64'd3);
        tick();
        drive(N, Y, N, 64'd0, Y, N, OP_ADD, N, N, Y);            // add x0,x0,x15
        check("addx0_wb", writedataa, 64'd3);
        tick();
        drive(N, Y, N, 64'd0, N, Y, OP_ADD, Y, N, Y);            // sd x5,0(x15)
        check("sd_rd2", readdata2, 64'd19);
        tick();
        drive(N, Y, N, 64'd0, Y, Y, OP_ADD, N, Y, N);            // ld x5,0(x15)
        check("ld3_wb", writedataa, 64'd19);
        tick();
        drive(N, Y, N, 64'd0, Y, N, OP_ADD, N, N, Y);            // add
        check("add3_wb", writedataa, 64'd22);
        tick();
        drive(N, Y, N, 64'd0, N, N, OP_SUB, N, N, Y);            // beq x5,x15
        check("beq_zero", 64'(zero), 64'd0);
        tick();
        drive(N, Y, Y, 64'h20, N, N, OP_ADD, N, N, Y);           // jump to 0x20
        check("beq_no_regchg", readdata2, 64'd22);
        tick();
        drive(N, N, Y, 64'h40, N, N, OP_ADD, N, N, Y);           // PCWrite=0
        check("jump_pc", PCNow, 64'h20);
        tick();
        drive(Y, Y, Y, 64'h40, Y, N, OP_ADD, Y, N, Y);           // reset mid-run
        check("hold_pc", PCNow, 64'h20);
        tick();
        drive(N, Y, Y, 64'h8, N, N, OP_SUB, N, N, Y);
        check("midrst_pc", PCNow, 64'd0);
        tick();
        drive(N, Y, Y, 64'hFFFF_FFFF_FFFF_FFFC, N, N, OP_SUB, N, N, Y);
        check("midrst_x15", readdata1, 64'd0);
        check("midrst_x5", readdata2, 64'd0);
        check("equal_zero", 64'(zero), 64'd1);
        tick();
        drive(N, Y, N, 64'd0, N, N, OP_ADD, N, N, Y);            // PC at top of space
        check("wrap_next4", PCNext4, 64'd0);
        tick();
        drive(N, Y, Y, 64'h104, N, N, OP_ADD, N, N, Y);
        tick();
        drive(N, Y, N, 64'd0, N, N, OP_ADD, N, N, Y);            // 0x104 aliases word 1
        check("alias_inst", 64'(Instruction), 64'h007302B3);
        tick();

        // Randomized controls, mostly walking the program with occasional jumps/resets
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 39) == 0);
            r_pcw = ($urandom_range(0, 7) != 0);
            r_jmp = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: r_npc = 64'({$urandom_range(0, 11), 2'b00});
                1: r_npc = {$urandom, $urandom};
                2: r_npc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: r_npc = 64'h100 + 64'({$urandom_range(0, 11), 2'b00});
            endcase
            drive(r_rst, r_pcw, r_jmp, r_npc,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
